// File: rtl/line_burst_adapter_pkg.sv
// ----------------------------------------------------------------------------
// line_burst_adapter_pkg
//   Shared definitions for the cache line <-> memory burst adapter.
//   - state_t     : adapter FSM states (IDLE, RD, WR, DONE)
//   - BEATS       : memory beats per cache line (LINE_BITS / BURST_BITS)
//   - BEAT_W      : width of the beat index / counter
//   - OFFSET_MASK : clears the line-offset bits of a byte address
// ----------------------------------------------------------------------------
package line_burst_adapter_pkg;

    localparam int LINE_BITS   = 256;
    localparam int BURST_BITS  = 64;
    localparam int ADDR_BITS   = 32;
    localparam int OFFSET_BITS = 5;

    localparam int BEATS  = LINE_BITS / BURST_BITS;
    localparam int BEAT_W = $clog2(BEATS);

    localparam logic [ADDR_BITS-1:0] OFFSET_MASK = {ADDR_BITS{1'b1}} << OFFSET_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/line_burst_adapter_beat_buffer.sv
// ----------------------------------------------------------------------------
// line_beat_buffer
//   beats x s_burst register file holding one cache line split into beats.
//   Shared by both directions of the adapter:
//     fill      : beat-indexed write port stores memory beats as they arrive
//     writeback : whole-line load captures the dirty line, then the
//                 beat-indexed read mux serialises it to memory
//   Ports:
//     clk, rst   clock, synchronous active-high reset (clears all beats)
//     load       load the whole line from load_line (has priority over we)
//     load_line  full line to load
//     we, widx   beat write enable / index, data on wdata
//     ridx       beat read index, beat presented on rdata
//     line_out   all beats packed, beat 0 in the low bits
// ----------------------------------------------------------------------------
module line_beat_buffer
    import line_burst_adapter_pkg::*;
#(
    parameter int s_burst = BURST_BITS,
    parameter int beats   = BEATS,
    parameter int idx_w   = BEAT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [s_burst*beats-1:0]   load_line,
    input  logic                       we,
    input  logic [idx_w-1:0]           widx,
    input  logic [s_burst-1:0]         wdata,
    input  logic [idx_w-1:0]           ridx,
    output logic [s_burst-1:0]         rdata,
    output logic [s_burst*beats-1:0]   line_out
);

    logic [s_burst-1:0] beat_reg [beats];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < beats; i++) begin
                beat_reg[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < beats; i++) begin
                beat_reg[i] <= load_line[i*s_burst +: s_burst];
            end
        end else if (we) begin
            beat_reg[widx] <= wdata;
        end
    end

    assign rdata = beat_reg[ridx];

    generate
        for (genvar gi = 0; gi < beats; gi++) begin : g_pack
            assign line_out[gi*s_burst +: s_burst] = beat_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/line_burst_adapter.sv
// ----------------------------------------------------------------------------
// line_burst_adapter
//   Bridges the cache's one-line-per-request interface to a memory that
//   moves a line as a burst of s_line/s_burst beats (beat 0 = low bits).
//   Fill: collects beats into a line, writeback: serialises a dirty line.
//
//   Cache side : line_i (writeback data), line_o (last completed fill line),
//                address_i, read_i, write_i, resp_o (1-cycle completion)
//   Memory side: burst_i (read beat), burst_o (write beat), address_o
//                (line aligned), read_o, write_o, resp_i (beat valid/accepted)
//   clk, rst   : clock, synchronous active-high reset
//
//   Optional build macro LINE_BURST_PERF_EN adds saturating counters:
//     perf_rd_o (completed fills), perf_wr_o (completed writebacks),
//     perf_stall_o (RD/WR cycles with resp_i low).
// ----------------------------------------------------------------------------
module line_burst_adapter
    import line_burst_adapter_pkg::*;
#(
    parameter int s_line   = LINE_BITS,
    parameter int s_burst  = BURST_BITS,
    parameter int s_addr   = ADDR_BITS,
    parameter int s_offset = OFFSET_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [s_line-1:0]   line_i,
    output logic [s_line-1:0]   line_o,
    input  logic [s_addr-1:0]   address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [s_burst-1:0]  burst_i,
    output logic [s_burst-1:0]  burst_o,
    output logic [s_addr-1:0]   address_o,
    output logic                read_o,
    output logic                write_o,
`ifdef LINE_BURST_PERF_EN
    output logic [31:0]         perf_rd_o,
    output logic [31:0]         perf_wr_o,
    output logic [31:0]         perf_stall_o,
`endif
    input  logic                resp_i
);

    localparam int beats  = s_line / s_burst;
    localparam int beat_w = $clog2(beats);

    // Standard geometry uses the shared constant; other geometries derive it.
    localparam logic [s_addr-1:0] addr_mask =
        (s_addr == ADDR_BITS && s_offset == OFFSET_BITS) ? s_addr'(OFFSET_MASK)
                                                         : ({s_addr{1'b1}} << s_offset);

    state_t              state_reg;
    logic [beat_w-1:0]   cnt_reg;
    logic                read_reg;
    logic                write_reg;
    logic                resp_reg;
    logic [s_addr-1:0]   addr_reg;
    logic [s_line-1:0]   line_reg;

    logic                last_beat;
    logic                buf_load;
    logic                buf_we;
    logic [s_burst-1:0]  buf_rdata;
    logic [s_line-1:0]   buf_line;

    assign last_beat = (cnt_reg == beat_w'(beats - 1));
    // write_i wins over read_i, so the buffer is loaded on any IDLE write.
    assign buf_load  = (state_reg == ST_IDLE) && write_i;
    assign buf_we    = (state_reg == ST_RD) && resp_i;

    line_beat_buffer #(
        .s_burst (s_burst),
        .beats   (beats),
        .idx_w   (beat_w)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .load_line (line_i),
        .we        (buf_we),
        .widx      (cnt_reg),
        .wdata     (burst_i),
        .ridx      (cnt_reg),
        .rdata     (buf_rdata),
        .line_out  (buf_line)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            read_reg  <= 1'b0;
            write_reg <= 1'b0;
            resp_reg  <= 1'b0;
            addr_reg  <= '0;
            line_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    resp_reg <= 1'b0;
                    if (write_i) begin
                        state_reg <= ST_WR;
                        write_reg <= 1'b1;
                        addr_reg  <= address_i & addr_mask;
                        cnt_reg   <= '0;
                    end else if (read_i) begin
                        state_reg <= ST_RD;
                        read_reg  <= 1'b1;
                        addr_reg  <= address_i & addr_mask;
                        cnt_reg   <= '0;
                    end
                end
                ST_RD: begin
                    if (resp_i) begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (last_beat) begin
                            // Last beat goes to the top slot; the buffer
                            // already holds the lower beats.
                            line_reg  <= {burst_i, buf_line[s_line-s_burst-1:0]};
                            read_reg  <= 1'b0;
                            resp_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_WR: begin
                    if (resp_i) begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (last_beat) begin
                            write_reg <= 1'b0;
                            resp_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    resp_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign read_o    = read_reg;
    assign write_o   = write_reg;
    assign resp_o    = resp_reg;
    assign address_o = addr_reg;
    assign line_o    = line_reg;
    // Beat is driven straight from the buffer so memory sees it in the
    // first WR cycle; quiet outside writebacks.
    assign burst_o   = (state_reg == ST_WR) ? buf_rdata : '0;

`ifdef LINE_BURST_PERF_EN
    logic [31:0] perf_rd_reg;
    logic [31:0] perf_wr_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_rd_reg    <= '0;
            perf_wr_reg    <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (state_reg == ST_RD && resp_i && last_beat && perf_rd_reg != 32'hFFFF_FFFF) begin
                perf_rd_reg <= perf_rd_reg + 32'd1;
            end
            if (state_reg == ST_WR && resp_i && last_beat && perf_wr_reg != 32'hFFFF_FFFF) begin
                perf_wr_reg <= perf_wr_reg + 32'd1;
            end
            if ((state_reg == ST_RD || state_reg == ST_WR) && !resp_i
                && perf_stall_reg != 32'hFFFF_FFFF) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_rd_o    = perf_rd_reg;
    assign perf_wr_o    = perf_wr_reg;
    assign perf_stall_o = perf_stall_reg;
`endif

endmodule
